// File: rtl/result_hex_sender.sv
// result_hex_sender
//  Captures a RES_W-bit result on the core's done strobe and streams it as
//  RES_W/4 ASCII hex characters, most significant nibble first, over a byte
//  valid/ready port. Results arriving mid-frame are dropped and recorded in a
//  sticky overrun flag.
//  Optional feature: define HEX_SENDER_CRLF_EN to append CR (0x0D) and
//  LF (0x0A) after the last digit of every frame.
//  RES_W must be a multiple of 4 and at least 8.
module result_hex_sender #(
   parameter int UPPERCASE = 1,
   parameter int RES_W     = 128
) (
   input  logic             clock_50M,
   input  logic             reset,
   input  logic [RES_W-1:0] result,
   input  logic             result_valid,
   output logic [7:0]       tx_data,
   output logic             tx_valid,
   input  logic             tx_ready,
   output logic             busy,
   output logic             frame_done,
   output logic             overrun
);

   localparam int NIB   = RES_W / 4;
   localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIB - 1);

`ifdef HEX_SENDER_CRLF_EN
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_TERM = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1
   } state_t;
`endif

   state_t             state_q, state_d;
   logic [RES_W-1:0]   shreg_q, shreg_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [7:0]         tx_data_q, tx_data_d;
   logic               tx_valid_q, tx_valid_d;
   logic               frame_done_q, frame_done_d;
   logic               overrun_q, overrun_d;
   logic               handshake_s;
`ifdef HEX_SENDER_CRLF_EN
   logic               term_lf_q, term_lf_d;   // 0: CR on the port, 1: LF on the port
`endif

   // Nibble to ASCII hex digit; letter case selected by UPPERCASE.
   function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
      logic [7:0] wide;
      wide = {4'h0, nib};
      if (nib < 4'd10) begin
         return 8'h30 + wide;
      end else if (UPPERCASE != 0) begin
         return 8'h37 + wide;
      end else begin
         return 8'h57 + wide;
      end
   endfunction

   assign handshake_s = tx_valid_q & tx_ready;

   // Next-state, datapath and output computation for the frame sequencer.
   always_comb begin
      state_d      = state_q;
      shreg_d      = shreg_q;
      count_d      = count_q;
      tx_data_d    = tx_data_q;
      tx_valid_d   = tx_valid_q;
      frame_done_d = 1'b0;
`ifdef HEX_SENDER_CRLF_EN
      term_lf_d    = term_lf_q;
`endif

      // A strobe while a frame is in flight is dropped but remembered.
      if (result_valid && (state_q != ST_IDLE)) begin
         overrun_d = 1'b1;
      end else begin
         overrun_d = overrun_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (result_valid) begin
               shreg_d    = result;
               count_d    = '0;
               tx_data_d  = hex_ascii(result[RES_W-1 -: 4]);
               tx_valid_d = 1'b1;
               state_d    = ST_SEND;
            end else begin
               tx_valid_d = 1'b0;
            end
         end
         ST_SEND: begin
            if (handshake_s) begin
               shreg_d = shreg_q << 4;
               count_d = count_q + CNT_W'(1);
               if (count_q == LAST_CNT) begin
`ifdef HEX_SENDER_CRLF_EN
                  state_d   = ST_TERM;
                  tx_data_d = 8'h0D;
                  term_lf_d = 1'b0;
`else
                  state_d      = ST_IDLE;
                  tx_valid_d   = 1'b0;
                  frame_done_d = 1'b1;
`endif
               end else begin
                  // Next digit comes from the freshly shifted register.
                  tx_data_d = hex_ascii(shreg_d[RES_W-1 -: 4]);
               end
            end else begin
               state_d = ST_SEND;
            end
         end
`ifdef HEX_SENDER_CRLF_EN
         ST_TERM: begin
            if (handshake_s) begin
               if (!term_lf_q) begin
                  tx_data_d = 8'h0A;
                  term_lf_d = 1'b1;
               end else begin
                  state_d      = ST_IDLE;
                  tx_valid_d   = 1'b0;
                  frame_done_d = 1'b1;
               end
            end else begin
               state_d = ST_TERM;
            end
         end
`endif
         default: begin
            state_d    = ST_IDLE;
            tx_valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset that abandons any frame.
   always_ff @(posedge clock_50M) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         shreg_q      <= '0;
         count_q      <= '0;
         tx_data_q    <= 8'h00;
         tx_valid_q   <= 1'b0;
         frame_done_q <= 1'b0;
         overrun_q    <= 1'b0;
`ifdef HEX_SENDER_CRLF_EN
         term_lf_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         shreg_q      <= shreg_d;
         count_q      <= count_d;
         tx_data_q    <= tx_data_d;
         tx_valid_q   <= tx_valid_d;
         frame_done_q <= frame_done_d;
         overrun_q    <= overrun_d;
`ifdef HEX_SENDER_CRLF_EN
         term_lf_q    <= term_lf_d;
`endif
      end
   end

   assign tx_data    = tx_data_q;
   assign tx_valid   = tx_valid_q;
   assign busy       = (state_q != ST_IDLE);
   assign frame_done = frame_done_q;
   assign overrun    = overrun_q;

endmodule
